arp_rewrite_pipe: RTL and testbench
===================================

Name: arp_rewrite_pipe

Overview:
- Parametrised next-hop ARP resolution and L2/L3 header rewrite stage in the router output-port-lookup pipeline, placed after the LPM stage.
- Buffers each packet and takes per-packet lookup metadata (next-hop IP, output port, bypass) on a sideband.
- Searches a register-programmable ARP table over multiple cycles. On a hit it rewrites destination and source MAC, decrements TTL and incrementally updates the IPv4 checksum. On a miss it steers the packet to the CPU queue paired with its source port.

Parameters:
C_S_AXI_DATA_WIDTH, 32, register/table word width
C_M_AXIS_DATA_WIDTH, 256, master stream data width (C_S_AXIS_DATA_WIDTH equal)
C_M_AXIS_TUSER_WIDTH, 128, master stream TUSER width (C_S_AXIS_TUSER_WIDTH equal)
SRC_PORT_POS, 16, TUSER source-port one-hot byte offset
DST_PORT_POS, 24, TUSER destination-port one-hot byte offset
TABLE_DEPTH, 32, ARP entries, power of 2, 4..256
ENTRIES_PER_CYCLE, 4, entries compared per search cycle; divides TABLE_DEPTH
NUM_PORTS, 4, physical ports, 1..4
META_DEPTH_BITS, 2, log2 of metadata FIFO depth

Ports:
AXI_ACLK  in  1  clock
AXI_RESETN  in  1  reset; synchronous, active-low
S_AXIS_TDATA/TSTRB/TUSER/TVALID/TREADY/TLAST  AXI4-Stream slave, widths per parameters
M_AXIS_TDATA/TSTRB/TUSER/TVALID/TREADY/TLAST  AXI4-Stream master, widths per parameters
lkp_nh  in  32  next-hop IPv4 address; sampled with the SOP beat
lkp_oq  in  8  output port index; sampled with the SOP beat
lkp_bypass  in  1  forward the packet unmodified; sampled with the SOP beat
port_mac  in  48*NUM_PORTS  port k MAC at [48k+47:48k]
tbl_wr_req/tbl_rd_req  in  1  table access strobes
tbl_wr_addr/tbl_rd_addr  in  log2(TABLE_DEPTH)  table index
tbl_wr_data  in  96  entry: [95] valid, [79:32] MAC, [31:0] IP
tbl_rd_data  out  96  read data
tbl_wr_ack/tbl_rd_ack  out  1  one-cycle acknowledge pulses
cnt_clear  in  1  clears all counters
arp_hit_count/arp_miss_count  out  32  statistics counters

Behaviour:
- Reset (AXI_RESETN low at a clock edge):
  - outputs: state IDLE; FIFOs empty; counters 0; acks 0; tbl_rd_data 0; M_AXIS_TVALID 0.
  - sop flag is set to 1.
  - table valid bits are cleared.
- Table access:
  - Write: entry updates at the edge; tbl_wr_ack is high the next cycle.
  - Read: tbl_rd_data and tbl_rd_ack are registered with 1-cycle latency.
  - A read and a write may be issued in the same cycle.
  - A search group compared in cycle c sees all writes from cycles before c.
- Input side:
  - Data FIFO is 4 deep, fallthrough.
  - S_AXIS_TREADY = !data_nearly_full && !meta_full.
  - The metadata FIFO is pushed on every accepted SOP beat.
  - sop flag clears on an accepted non-last beat and sets on an accepted TLAST beat.
- State machine IDLE / SEARCH / HEAD / BODY:
  - IDLE:
    - Waits until data FIFO and metadata FIFO are both non-empty.
    - Non-bypass: goes to SEARCH with group 0.
    - Bypass: goes directly to HEAD with no rewrite.
  - SEARCH:
    - One group of ENTRIES_PER_CYCLE entries per cycle, for TABLE_DEPTH/ENTRIES_PER_CYCLE cycles (8 at defaults).
    - Match = valid && IP == lkp_nh. The lowest matching index wins.
    - After the last group: HEAD.
    - An early match does not shorten the search, so latency is fixed.
  - HEAD:
    - M_AXIS_TVALID=1 with the rewritten first beat, held stable until M_AXIS_TREADY.
    - On handshake: BODY, or IDLE if TLAST. The metadata FIFO pops.
  - BODY: pass-through beats; the handshake on the TLAST beat returns to IDLE.
- Hit rewrite (requires lkp_oq < NUM_PORTS):
  - TUSER destination byte = one-hot bit 2*oq.
  - TDATA[255:208] = entry MAC; TDATA[207:160] = port_mac[oq].
  - TTL TDATA[79:72] is decremented.
  - Checksum TDATA[63:48] = ck + 16'h0100, with end-around carry. Result 16'hFFFF is kept as-is.
  - arp_hit_count increments.
- Miss, or lkp_oq >= NUM_PORTS:
  - TDATA is unchanged.
  - TUSER destination = bit 2k+1 for source bit 2k. If several source bits are set, the highest k wins. If none are set, 0.
  - arp_miss_count increments.
- Counters:
  - Update in the HEAD handshake cycle.
  - Saturate at 32'hFFFFFFFF.
  - cnt_clear has priority over an increment in the same cycle.
- Latency: a non-bypass SOP at the FIFO head in IDLE at cycle t gives M_AXIS_TVALID at t+1+TABLE_DEPTH/ENTRIES_PER_CYCLE. Bypass gives t+1.
- Back-to-back packets: the next search starts the cycle after the prior TLAST handshake.

Optional Feature:
- ARP_TTL_EXCEPT_EN defined:
  - A hit packet with TTL <= 1 is not rewritten; it goes to the CPU queue per the miss rule.
  - ttl_except_count (out, 32, saturating, cleared by cnt_clear) increments; arp_hit_count does not.
- Undefined: TTL is decremented unconditionally (1 becomes 0, 0 wraps to 8'hFF) and the port is absent.

Test Plan:
- Entry 5 = {valid, MAC 0x0A0B0C0D0E0F, IP 10.0.0.2}; packet nh=10.0.0.2, oq=2, TTL 64, ck 0x1234 -> DST byte 0x10, dst MAC 0x0A0B0C0D0E0F, src MAC port_mac[2], TTL 63, ck 0x1334, arp_hit_count=1, M_AXIS_TVALID 9 cycles after IDLE.
- No matching entry; SRC byte 0x04 -> DST byte 0x08, TDATA unchanged, arp_miss_count=1.
- Entries 3 and 20 both match the next-hop IP with different MACs -> entry 3 MAC used.
- ck 0xFF00 with TTL decrement -> ck 0x0001; lkp_oq=7 -> treated as miss.
- 3-beat packet with M_AXIS_TREADY toggling 1/0 each cycle, then a bypass packet back-to-back -> beats in order, none lost, bypass packet unmodified; AXI_RESETN low mid-BODY -> next cycle IDLE, FIFOs empty, counters 0.
- Write entry 0 then read it 1 cycle later -> tbl_rd_data equals the written value, one-cycle ack pulses; counter at 32'hFFFFFFFF does not wrap; cnt_clear together with a hit -> 0.

Source files
------------

// File: rtl/arp_rewrite_pipe.sv
// arp_rewrite_pipe: next-hop ARP lookup with MAC/TTL/checksum rewrite, or CPU steering on a miss.
// Define ARP_TTL_EXCEPT_EN to divert TTL<=1 hits to the CPU and count them on ttl_except_count.
module arp_rewrite_pipe #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXIS_DATA_WIDTH = 256,
  parameter int C_S_AXIS_DATA_WIDTH = C_M_AXIS_DATA_WIDTH,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = C_M_AXIS_TUSER_WIDTH,
  parameter int SRC_PORT_POS = 16,
  parameter int DST_PORT_POS = 24,
  parameter int TABLE_DEPTH = 32,
  parameter int ENTRIES_PER_CYCLE = 4,
  parameter int NUM_PORTS = 4,
  parameter int META_DEPTH_BITS = 2
) (
  input  logic AXI_ACLK,
  input  logic AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] S_AXIS_TUSER,
  input  logic S_AXIS_TVALID,
  output logic S_AXIS_TREADY,
  input  logic S_AXIS_TLAST,
  output logic [C_M_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0] M_AXIS_TUSER,
  output logic M_AXIS_TVALID,
  input  logic M_AXIS_TREADY,
  output logic M_AXIS_TLAST,
  input  logic [31:0] lkp_nh,
  input  logic [7:0] lkp_oq,
  input  logic lkp_bypass,
  input  logic [48*NUM_PORTS-1:0] port_mac,
  input  logic tbl_wr_req,
  input  logic tbl_rd_req,
  input  logic [$clog2(TABLE_DEPTH)-1:0] tbl_wr_addr,
  input  logic [$clog2(TABLE_DEPTH)-1:0] tbl_rd_addr,
  input  logic [95:0] tbl_wr_data,
  output logic [95:0] tbl_rd_data,
  output logic tbl_wr_ack,
  output logic tbl_rd_ack,
  input  logic cnt_clear,
  output logic [C_S_AXI_DATA_WIDTH-1:0] arp_hit_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] arp_miss_count
`ifdef ARP_TTL_EXCEPT_EN
  , output logic [C_S_AXI_DATA_WIDTH-1:0] ttl_except_count
`endif
);
  localparam int AW = $clog2(TABLE_DEPTH);
  localparam int NG = TABLE_DEPTH / ENTRIES_PER_CYCLE;
  localparam int GW = $clog2(NG) + 1;
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int FW = DW + DW/8 + UW + 1;
  localparam int MD = 1 << META_DEPTH_BITS;
  localparam int CW = C_S_AXI_DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, SEARCH, HEAD, BODY} state_t;
  state_t state_q;
  logic [TABLE_DEPTH-1:0] tv_q;
  logic [47:0] tmac_q [TABLE_DEPTH];
  logic [31:0] tip_q [TABLE_DEPTH];
  logic [FW-1:0] dfifo_q [4];
  logic [1:0] drd_q, dwr_q;
  logic [2:0] dcnt_q;
  logic [40:0] mfifo_q [MD];
  logic [META_DEPTH_BITS-1:0] mrd_q, mwr_q;
  logic [META_DEPTH_BITS:0] mcnt_q;
  logic sop_q, found_q;
  logic [47:0] fmac_q;
  logic [GW-1:0] grp_q;
  logic [CW-1:0] hit_cnt_q, miss_cnt_q;
  logic d_push, d_pop, m_push, out_hs, head_hs;
  logic [DW-1:0] h_data;
  logic [DW/8-1:0] h_strb;
  logic [UW-1:0] h_user;
  logic h_last, m_byp;
  logic [7:0] m_oq, miss_dst;
  logic [31:0] m_nh;
  logic [AW-1:0] idx;
  logic g_hit, oq_ok, ttl_ok, do_hit, hit_inc, miss_inc;
  logic [47:0] g_mac, src_mac;
  logic [16:0] ck_sum;
  logic unused_wr;
  assign unused_wr = ^tbl_wr_data[94:80];
  assign {h_last, h_user, h_strb, h_data} = dfifo_q[drd_q];
  assign {m_byp, m_oq, m_nh} = mfifo_q[mrd_q];
  assign S_AXIS_TREADY = dcnt_q < 3'd3 && mcnt_q != (META_DEPTH_BITS+1)'(MD);
  assign d_push = S_AXIS_TVALID && S_AXIS_TREADY;
  assign m_push = d_push && sop_q;
  assign M_AXIS_TVALID = state_q == HEAD || (state_q == BODY && dcnt_q != 3'd0);
  assign out_hs = M_AXIS_TVALID && M_AXIS_TREADY;
  assign d_pop = out_hs;
  assign head_hs = out_hs && state_q == HEAD;
  assign oq_ok = m_oq < 8'(NUM_PORTS);
  assign ck_sum = {1'b0, h_data[63:48]} + 17'h00100;
`ifdef ARP_TTL_EXCEPT_EN
  assign ttl_ok = h_data[79:72] > 8'd1;
`else
  assign ttl_ok = 1'b1;
`endif
  assign do_hit = found_q && oq_ok && ttl_ok;
  assign hit_inc = head_hs && !m_byp && do_hit;
  assign miss_inc = head_hs && !m_byp && !(found_q && oq_ok);
  assign arp_hit_count = hit_cnt_q;
  assign arp_miss_count = miss_cnt_q;
  // descending scan so the lowest matching index in the group wins
  always_comb begin
    g_hit = 1'b0;
    g_mac = '0;
    idx = '0;
    for (int e = ENTRIES_PER_CYCLE-1; e >= 0; e--) begin
      idx = AW'(int'(grp_q) * ENTRIES_PER_CYCLE + e);
      if (tv_q[idx] && tip_q[idx] == m_nh) begin
        g_hit = 1'b1;
        g_mac = tmac_q[idx];
      end
    end
  end
  always_comb begin
    src_mac = '0;
    for (int k = 0; k < NUM_PORTS; k++) if (m_oq == 8'(k)) src_mac = port_mac[48*k +: 48];
    miss_dst = '0;
    for (int k = 0; k < 4; k++) if (h_user[SRC_PORT_POS + 2*k]) miss_dst = 8'(2) << (2*k);
    M_AXIS_TDATA = h_data;
    M_AXIS_TSTRB = h_strb;
    M_AXIS_TUSER = h_user;
    M_AXIS_TLAST = h_last;
    if (state_q == HEAD && !m_byp) begin
      if (do_hit) begin
        M_AXIS_TDATA[DW-1 -: 48] = fmac_q;
        M_AXIS_TDATA[DW-49 -: 48] = src_mac;
        M_AXIS_TDATA[79:72] = h_data[79:72] - 8'd1;
        M_AXIS_TDATA[63:48] = ck_sum[15:0] + {15'b0, ck_sum[16]};
        M_AXIS_TUSER[DST_PORT_POS +: 8] = 8'(1) << {m_oq[2:0], 1'b0};
      end else M_AXIS_TUSER[DST_PORT_POS +: 8] = miss_dst;
    end
  end
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      state_q <= IDLE;
      grp_q <= '0;
      found_q <= 1'b0;
      fmac_q <= '0;
    end else case (state_q)
      IDLE: if (dcnt_q != 3'd0 && mcnt_q != '0) begin
        state_q <= m_byp ? HEAD : SEARCH;
        grp_q <= '0;
        found_q <= 1'b0;
      end
      SEARCH: begin
        if (g_hit && !found_q) begin
          found_q <= 1'b1;
          fmac_q <= g_mac;
        end
        grp_q <= grp_q + GW'(1);
        if (grp_q == GW'(NG-1)) state_q <= HEAD;
      end
      HEAD: if (out_hs) state_q <= h_last ? IDLE : BODY;
      default: if (out_hs && h_last) state_q <= IDLE;
    endcase
  end
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      drd_q <= '0;
      dwr_q <= '0;
      dcnt_q <= '0;
      mrd_q <= '0;
      mwr_q <= '0;
      mcnt_q <= '0;
      sop_q <= 1'b1;
      tv_q <= '0;
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
      tbl_wr_ack <= 1'b0;
      tbl_rd_ack <= 1'b0;
      tbl_rd_data <= '0;
    end else begin
      drd_q <= drd_q + 2'(d_pop);
      dwr_q <= dwr_q + 2'(d_push);
      dcnt_q <= dcnt_q + 3'(d_push) - 3'(d_pop);
      mrd_q <= mrd_q + META_DEPTH_BITS'(head_hs);
      mwr_q <= mwr_q + META_DEPTH_BITS'(m_push);
      mcnt_q <= mcnt_q + (META_DEPTH_BITS+1)'(m_push) - (META_DEPTH_BITS+1)'(head_hs);
      sop_q <= d_push ? S_AXIS_TLAST : sop_q;
      if (tbl_wr_req) tv_q[tbl_wr_addr] <= tbl_wr_data[95];
      tbl_wr_ack <= tbl_wr_req;
      tbl_rd_ack <= tbl_rd_req;
      if (tbl_rd_req) tbl_rd_data <= {tv_q[tbl_rd_addr], 15'b0, tmac_q[tbl_rd_addr], tip_q[tbl_rd_addr]};
      hit_cnt_q <= cnt_clear ? '0 : hit_cnt_q + CW'(hit_inc && ~&hit_cnt_q);
      miss_cnt_q <= cnt_clear ? '0 : miss_cnt_q + CW'(miss_inc && ~&miss_cnt_q);
    end
  end
  always_ff @(posedge AXI_ACLK) begin
    if (d_push) dfifo_q[dwr_q] <= {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
    if (m_push) mfifo_q[mwr_q] <= {lkp_bypass, lkp_oq, lkp_nh};
    if (tbl_wr_req) begin
      tmac_q[tbl_wr_addr] <= tbl_wr_data[79:32];
      tip_q[tbl_wr_addr] <= tbl_wr_data[31:0];
    end
  end
`ifdef ARP_TTL_EXCEPT_EN
  logic [CW-1:0] ttl_cnt_q;
  assign ttl_except_count = ttl_cnt_q;
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) ttl_cnt_q <= '0;
    else ttl_cnt_q <= cnt_clear ? '0 : ttl_cnt_q + CW'(head_hs && !m_byp && found_q && oq_ok && !ttl_ok && ~&ttl_cnt_q);
  end
`endif
endmodule

// File: tb/tb_arp_rewrite_pipe.sv
// tb_arp_rewrite_pipe: randomized and directed traffic against a packet-level scoreboard model.
`timescale 1ns/1ps
module tb_arp_rewrite_pipe;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  logic [255:0] s_data, m_data;
  logic [31:0] s_strb, m_strb;
  logic [127:0] s_user, m_user;
  logic s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic [31:0] lkp_nh;
  logic [7:0] lkp_oq;
  logic lkp_bypass;
  logic [191:0] port_mac;
  logic wr_req, rd_req, wr_ack, rd_ack;
  logic [4:0] wr_addr, rd_addr;
  logic [95:0] wr_data, rd_data;
  logic cnt_clear;
  logic [31:0] hit_cnt, miss_cnt;
  int errors = 0, checks = 0, rdy_mode = 0, exp_hit = 0, exp_miss = 0;
  logic t_valid [32];
  logic [47:0] t_mac [32];
  logic [31:0] t_ip [32];
  logic [255:0] q_d[$];
  logic [127:0] q_u[$];
  logic q_l[$];
  logic [255:0] last_d;
  logic [127:0] last_u;
  logic mon_sop = 1'b1;

  arp_rewrite_pipe dut (
    .AXI_ACLK(clk), .AXI_RESETN(rstn),
    .S_AXIS_TDATA(s_data), .S_AXIS_TSTRB(s_strb), .S_AXIS_TUSER(s_user),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready), .S_AXIS_TLAST(s_last),
    .M_AXIS_TDATA(m_data), .M_AXIS_TSTRB(m_strb), .M_AXIS_TUSER(m_user),
    .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready), .M_AXIS_TLAST(m_last),
    .lkp_nh(lkp_nh), .lkp_oq(lkp_oq), .lkp_bypass(lkp_bypass), .port_mac(port_mac),
    .tbl_wr_req(wr_req), .tbl_rd_req(rd_req), .tbl_wr_addr(wr_addr), .tbl_rd_addr(rd_addr),
    .tbl_wr_data(wr_data), .tbl_rd_data(rd_data), .tbl_wr_ack(wr_ack), .tbl_rd_ack(rd_ack),
    .cnt_clear(cnt_clear), .arp_hit_count(hit_cnt), .arp_miss_count(miss_cnt)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // first-beat expectation straight from the lookup and rewrite rules
  task automatic predict(input logic [255:0] d, input logic [127:0] u, input logic [31:0] nh,
                         input logic [7:0] oq, input logic byp,
                         output logic [255:0] ed, output logic [127:0] eu);
    int hit, ck;
    hit = -1;
    ed = d;
    eu = u;
    if (byp) return;
    for (int i = 0; i < 32; i++) if (hit < 0 && t_valid[i] && t_ip[i] == nh) hit = i;
    eu[31:24] = 8'h00;
    if (hit >= 0 && oq < 8'd4) begin
      ed[255:208] = t_mac[hit];
      ed[207:160] = port_mac[int'(oq)*48 +: 48];
      ed[79:72] = d[79:72] - 8'd1;
      ck = int'(d[63:48]) + 256;
      if (ck > 32'hFFFF) ck -= 32'hFFFF;
      ed[63:48] = ck[15:0];
      eu[24 + 2*int'(oq)] = 1'b1;
      exp_hit++;
    end else begin
      for (int k = 3; k >= 0; k--) if (u[16 + 2*k]) begin
        eu[24 + 2*k + 1] = 1'b1;
        break;
      end
      exp_miss++;
    end
  endtask

  task automatic send_pkt(input int n, input int nsend, input logic [31:0] nh, input logic [7:0] oq,
                          input logic byp, input logic [7:0] src, input logic [7:0] ttl, input logic [15:0] ck);
    logic [255:0] d, ed;
    logic [127:0] u, eu;
    int w;
    for (int b = 0; b < n; b++) begin
      d = rnd256();
      u = rnd256()[127:0];
      if (b == 0) begin
        d[79:72] = ttl;
        d[63:48] = ck;
        u[23:16] = src;
        predict(d, u, nh, oq, byp, ed, eu);
      end else begin
        ed = d;
        eu = u;
      end
      q_d.push_back(ed);
      q_u.push_back(eu);
      q_l.push_back(b == n-1);
      if (b < nsend) begin
        s_data = d;
        s_user = u;
        s_last = (b == n-1);
        s_valid = 1'b1;
        if (b == 0) begin
          lkp_nh = nh;
          lkp_oq = oq;
          lkp_bypass = byp;
        end
        w = 0;
        while (!s_ready && w < 200) begin
          tick();
          w++;
        end
        chk("s_ready_wait", 256'(w < 200), 256'd1);
        tick();
        s_valid = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q_d.size() != 0 || m_valid) && w < 3000) begin
      tick();
      w++;
    end
    chk("drain", 256'(q_d.size()), 256'd0);
    tick();
  endtask

  task automatic tbl_write(input int a, input logic v, input logic [47:0] mac, input logic [31:0] ip);
    wr_req = 1'b1;
    wr_addr = 5'(a);
    wr_data = {v, 15'b0, mac, ip};
    t_valid[a] = v;
    t_mac[a] = mac;
    t_ip[a] = ip;
    tick();
    wr_req = 1'b0;
    chk("wr_ack", 256'(wr_ack), 256'd1);
  endtask

  task automatic latency(input int exp, input string tag);
    int n;
    n = 0;
    while (!m_valid && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 256'(n), 256'(exp));
  endtask

  always @(negedge clk) if (rstn && m_valid && m_ready) begin
    chk("beat_expected", 256'(q_d.size() > 0), 256'd1);
    if (q_d.size() > 0) begin
      chk("tdata", m_data, q_d.pop_front());
      chk("tuser", 256'(m_user), 256'(q_u.pop_front()));
      chk("tlast", 256'(m_last), 256'(q_l.pop_front()));
      chk("tstrb", 256'(m_strb), 256'(s_strb));
    end
    if (mon_sop) begin
      last_d = m_data;
      last_u = m_user;
    end
    mon_sop = m_last;
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      tick();
      m_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~m_ready : rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    s_valid = 0; s_last = 0; s_data = '0; s_user = '0; s_strb = '1;
    lkp_nh = '0; lkp_oq = '0; lkp_bypass = 0;
    wr_req = 0; rd_req = 0; wr_addr = '0; rd_addr = '0; wr_data = '0; cnt_clear = 0;
    port_mac = {rnd256()[191:0]};
    for (int i = 0; i < 32; i++) t_valid[i] = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    chk("rst_m_valid", 256'(m_valid), 256'd0);
    chk("rst_s_ready", 256'(s_ready), 256'd1);
    chk("rst_hit_cnt", 256'(hit_cnt), 256'd0);
    chk("rst_miss_cnt", 256'(miss_cnt), 256'd0);
    chk("rst_acks", 256'({wr_ack, rd_ack}), 256'd0);
    chk("rst_rd_data", 256'(rd_data), 256'd0);
    tbl_write(0, 1'b1, 48'h112233445566, 32'hC0A80001);
    rd_req = 1'b1;
    rd_addr = 5'd0;
    tick();
    rd_req = 1'b0;
    chk("rd_ack", 256'(rd_ack), 256'd1);
    chk("rd_data", 256'(rd_data), 256'({1'b1, 15'b0, 48'h112233445566, 32'hC0A80001}));
    chk("wr_ack_pulse", 256'(wr_ack), 256'd0);
    tick();
    chk("rd_ack_pulse", 256'(rd_ack), 256'd0);
    tbl_write(5, 1'b1, 48'h0A0B0C0D0E0F, 32'h0A000002);
    send_pkt(1, 1, 32'h0A000002, 8'd2, 1'b0, 8'h01, 8'd64, 16'h1234);
    latency(9, "lat_search");
    drain();
    chk("hit_dst_byte", 256'(last_u[31:24]), 256'h10);
    chk("hit_dst_mac", 256'(last_d[255:208]), 256'h0A0B0C0D0E0F);
    chk("hit_src_mac", 256'(last_d[207:160]), 256'(port_mac[143:96]));
    chk("hit_ttl", 256'(last_d[79:72]), 256'd63);
    chk("hit_ck", 256'(last_d[63:48]), 256'h1334);
    chk("hit_cnt1", 256'(hit_cnt), 256'd1);
    send_pkt(1, 1, 32'h0A000063, 8'd1, 1'b0, 8'h04, 8'd30, 16'hABCD);
    drain();
    chk("miss_dst_byte", 256'(last_u[31:24]), 256'h08);
    chk("miss_cnt1", 256'(miss_cnt), 256'd1);
    tbl_write(3, 1'b1, 48'hAAAAAAAAAAAA, 32'h0A000007);
    tbl_write(20, 1'b1, 48'hBBBBBBBBBBBB, 32'h0A000007);
    send_pkt(2, 2, 32'h0A000007, 8'd0, 1'b0, 8'h01, 8'd9, 16'h0000);
    drain();
    chk("lowest_idx_mac", 256'(last_d[255:208]), 256'hAAAAAAAAAAAA);
    send_pkt(1, 1, 32'h0A000002, 8'd1, 1'b0, 8'h01, 8'd5, 16'hFF00);
    drain();
    chk("ck_carry", 256'(last_d[63:48]), 256'h0001);
    send_pkt(1, 1, 32'h0A000002, 8'd7, 1'b0, 8'h41, 8'd5, 16'h1111);
    drain();
    chk("oq7_dst_byte", 256'(last_u[31:24]), 256'h80);
    send_pkt(1, 1, 32'h0A000002, 8'd0, 1'b1, 8'h01, 8'd5, 16'h2222);
    latency(1, "lat_bypass");
    drain();
    chk("hit_cnt_dir", 256'(hit_cnt), 256'(exp_hit));
    chk("miss_cnt_dir", 256'(miss_cnt), 256'(exp_miss));
    rdy_mode = 1;
    send_pkt(3, 3, 32'h0A000002, 8'd3, 1'b0, 8'h04, 8'd100, 16'h4321);
    send_pkt(2, 2, 32'h0A000002, 8'd3, 1'b1, 8'h04, 8'd100, 16'h4321);
    drain();
    rdy_mode = 0;
    cnt_clear = 1'b1;
    send_pkt(1, 1, 32'h0A000002, 8'd0, 1'b0, 8'h01, 8'd40, 16'h0F0F);
    drain();
    cnt_clear = 1'b0;
    exp_hit = 0;
    exp_miss = 0;
    chk("clear_hit", 256'(hit_cnt), 256'd0);
    chk("clear_miss", 256'(miss_cnt), 256'd0);
    for (int i = 0; i < 32; i++)
      tbl_write(i, 1'($urandom_range(0, 3) != 0), rnd256()[47:0], 32'h0A000000 | $urandom_range(0, 15));
    rdy_mode = 2;
    for (int p = 0; p < 40; p++)
      send_pkt($urandom_range(1, 4), 4, 32'h0A000000 | $urandom_range(0, 19),
               $urandom_range(0, 9) == 0 ? 8'd7 : 8'($urandom_range(0, 4)),
               1'($urandom_range(0, 6) == 0), 8'($urandom), 8'($urandom), 16'($urandom));
    drain();
    rdy_mode = 0;
    chk("rand_hit_cnt", 256'(hit_cnt), 256'(exp_hit));
    chk("rand_miss_cnt", 256'(miss_cnt), 256'(exp_miss));
    send_pkt(3, 1, 32'h0A000002, 8'd0, 1'b1, 8'h01, 8'd5, 16'h3333);
    repeat (4) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    q_d.delete();
    q_u.delete();
    q_l.delete();
    mon_sop = 1'b1;
    exp_hit = 0;
    exp_miss = 0;
    for (int i = 0; i < 32; i++) t_valid[i] = 1'b0;
    chk("mid_rst_m_valid", 256'(m_valid), 256'd0);
    chk("mid_rst_s_ready", 256'(s_ready), 256'd1);
    chk("mid_rst_hit", 256'(hit_cnt), 256'd0);
    chk("mid_rst_miss", 256'(miss_cnt), 256'd0);
    send_pkt(2, 2, 32'h0A000002, 8'd1, 1'b0, 8'h10, 8'd20, 16'h5555);
    drain();
    chk("post_rst_miss", 256'(miss_cnt), 256'd1);
    chk("post_rst_hit", 256'(hit_cnt), 256'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
